// File: rtl/seg_mux_driver.sv
// Multiplexed hex seven-segment driver with anti-ghost blanking,
// brightness control, leading-zero blanking and frame-synchronous shadow.
module seg_mux_driver #(
    parameter int DIGITS = 4,
    parameter int SLOT   = 260,
    parameter int BLANK  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [3:0]            bright,
    input  logic                  lzb,
    input  logic                  en,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int CW = $clog2(SLOT);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int OW = 22;

    logic [CW-1:0]          cnt;
    logic [DW-1:0]          dig;
    logic [4*DIGITS-1:0]    shd;
    logic [DIGITS-1:0]      shd_dp;

    logic [OW-1:0]          on_len;
    logic                   in_win;
    logic [3:0]             nib;
    logic                   dpb;
    logic                   zk;
    logic [DIGITS-1:0]      zhi;
    logic                   blank;
    logic                   lit;
    logic                   last_cnt;
    logic                   last_dig;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        unique case (v)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    // Lit window, current digit's shadow nibble and leading-zero state.
    always_comb begin
        on_len = (OW'(SLOT - BLANK) * (OW'(bright) + OW'(1))) >> 4;
        in_win = (OW'(cnt) >= OW'(BLANK)) &&
                 (OW'(cnt) < OW'(BLANK) + on_len);
        zhi = '0;
        zhi[DIGITS-1] = (shd[4*DIGITS-1 -: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zhi[k] = zhi[k+1] && (shd[4*k +: 4] == 4'h0);
        end
        nib = 4'h0;
        dpb = 1'b0;
        zk  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (DW'(k) == dig) begin
                nib = shd[4*k +: 4];
                dpb = shd_dp[k];
                zk  = zhi[k];
            end
        end
        blank    = lzb && zk && (dig != '0);
        lit      = in_win && en && !blank;
        last_cnt = (cnt == CW'(SLOT - 1));
        last_dig = (dig == DW'(DIGITS - 1));
    end

    // Slot/digit counters, frame-boundary shadow load and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dig        <= '0;
            shd        <= '0;
            shd_dp     <= '0;
            sel        <= '1;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= last_cnt ? '0 : cnt + CW'(1);
            frame_tick <= last_cnt && last_dig;
            if (last_cnt) begin
                dig <= last_dig ? '0 : dig + DW'(1);
            end
            if (last_cnt && last_dig) begin
                shd    <= data;
                shd_dp <= dp;
            end
            if (lit) begin
                sel <= ~(DIGITS'(1) << dig);
                seg <= {~dpb, hex7(nib)};
            end else begin
                sel <= '1;
                seg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed bench for seg_mux_driver at default parameters
// (4 digits, 260-cycle slots, 10 blank cycles).
module tb_seg_mux_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  bright;
    logic        lzb;
    logic        en;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    seg_mux_driver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .dp         (dp),
        .bright     (bright),
        .lzb        (lzb),
        .en         (en),
        .sel        (sel),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Observe one 260-cycle slot: lit start, lit length, lit sel/seg,
    // inconsistencies and frame ticks seen.
    task automatic grab_slot(output int first, output int nlit,
                             output logic [3:0] s, output logic [7:0] g,
                             output int nbad, output int nticks);
        first = -1; nlit = 0; s = 4'hF; g = 8'hFF; nbad = 0; nticks = 0;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (frame_tick) nticks++;
            if (sel !== 4'hF) begin
                if (first < 0) first = i;
                if (nlit > 0 && (sel !== s || seg !== g)) nbad++;
                s = sel;
                g = seg;
                nlit++;
            end else if (seg !== 8'hFF) begin
                nbad++;
            end
        end
    endtask

    // Cycles until frame_tick is seen; -1 if none within the limit.
    task automatic wait_tick(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic skip_frame();
        int n;
        wait_tick(1100, n);
        total++;
        if (n !== 1040) begin
            bad++;
            $display("FAIL skip_frame period got=%0d want=1040", n);
        end
    endtask

    task automatic test_reset();
        int e_sel = 0, e_seg = 0, e_ft = 0;
        rst_n = 1'b0;
        data = 16'h1234; dp = 4'h0; bright = 4'd15; lzb = 1'b0; en = 1'b1;
        #2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel !== 4'hF) e_sel++;
            if (seg !== 8'hFF) e_seg++;
            if (frame_tick !== 1'b0) e_ft++;
        end
        total++;
        if (e_sel != 0) begin bad++; $display("FAIL reset_sel got=%h want=f", sel); end
        total++;
        if (e_seg != 0) begin bad++; $display("FAIL reset_seg got=%h want=ff", seg); end
        total++;
        if (e_ft != 0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    endtask

    task automatic test_first_frame();
        int f, nl, nb, nt, n;
        logic [3:0] s;
        logic [7:0] g;
        #1 rst_n = 1'b1;
        grab_slot(f, nl, s, g, nb, nt);
        total++;
        if (f !== 10 || nl !== 250 || nb !== 0) begin
            bad++;
            $display("FAIL first_win first=%0d lit=%0d bad=%0d want 10/250/0", f, nl, nb);
        end
        total++;
        if (s !== 4'hE || g !== 8'hC0) begin
            bad++;
            $display("FAIL first_zero sel=%h seg=%h want e/c0", s, g);
        end
        wait_tick(1100, n);
        total++;
        if (n !== 780) begin
            bad++;
            $display("FAIL first_tick got=%0d want=780", n);
        end
    endtask

    task automatic test_digits();
        int f, nl, nb, nt;
        logic [3:0] s;
        logic [7:0] g;
        logic [3:0] xs [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] xg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        for (int d = 0; d < 4; d++) begin
            grab_slot(f, nl, s, g, nb, nt);
            total++;
            if (f !== 10 || nl !== 250 || nb !== 0 || s !== xs[d] || g !== xg[d]) begin
                bad++;
                $display("FAIL digit%0d first=%0d lit=%0d bad=%0d sel=%h seg=%h want 10/250/0/%h/%h",
                         d, f, nl, nb, s, g, xs[d], xg[d]);
            end
            total++;
            if (nt !== (d == 3 ? 1 : 0)) begin
                bad++;
                $display("FAIL digit%0d_ticks got=%0d", d, nt);
            end
        end
    endtask

    task automatic test_lzb();
        int f, nl, nb, nt;
        logic [3:0] s;
        logic [7:0] g;
        int xl1 [4] = '{250, 250, 0, 0};
        logic [7:0] xg1 [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
        logic [7:0] xg0 [4] = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
        data = 16'h0050;
        skip_frame();
        lzb = 1'b1;
        for (int d = 0; d < 4; d++) begin
            grab_slot(f, nl, s, g, nb, nt);
            total++;
            if (nl !== xl1[d] || nb !== 0 || g !== xg1[d]) begin
                bad++;
                $display("FAIL lzb_on d%0d lit=%0d bad=%0d seg=%h want %0d/0/%h",
                         d, nl, nb, g, xl1[d], xg1[d]);
            end
        end
        lzb = 1'b0;
        for (int d = 0; d < 4; d++) begin
            grab_slot(f, nl, s, g, nb, nt);
            total++;
            if (nl !== 250 || nb !== 0 || g !== xg0[d]) begin
                bad++;
                $display("FAIL lzb_off d%0d lit=%0d bad=%0d seg=%h want 250/0/%h",
                         d, nl, nb, g, xg0[d]);
            end
        end
    endtask

    task automatic test_tearing();
        int f, nl, nb, nt;
        logic [3:0] s;
        logic [7:0] g;
        int stale = 0;
        data = 16'h1111;
        skip_frame();
        grab_slot(f, nl, s, g, nb, nt);
        data = 16'h2222;
        for (int d = 1; d < 4; d++) begin
            grab_slot(f, nl, s, g, nb, nt);
            if (g !== 8'hF9 || nb !== 0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL tear_hold last seg=%h want f9", g);
        end
        grab_slot(f, nl, s, g, nb, nt);
        total++;
        if (g !== 8'hA4 || s !== 4'hE) begin
            bad++;
            $display("FAIL tear_new seg=%h sel=%h want a4/e", g, s);
        end
    endtask

    task automatic test_bright();
        int f, nl, nb, nt, n;
        logic [3:0] s;
        logic [7:0] g;
        bright = 4'd0;
        grab_slot(f, nl, s, g, nb, nt);
        total++;
        if (f !== 10 || nl !== 15 || nb !== 0) begin
            bad++;
            $display("FAIL bright0 first=%0d lit=%0d want 10/15", f, nl);
        end
        wait_tick(1100, n);
        total++;
        if (n !== 520) begin bad++; $display("FAIL bright0_tick got=%0d want=520", n); end
        wait_tick(1100, n);
        total++;
        if (n !== 1040) begin bad++; $display("FAIL frame_period got=%0d want=1040", n); end
        bright = 4'd7;
        grab_slot(f, nl, s, g, nb, nt);
        total++;
        if (f !== 10 || nl !== 125 || nb !== 0) begin
            bad++;
            $display("FAIL bright7 first=%0d lit=%0d want 10/125", f, nl);
        end
        bright = 4'd15;
        wait_tick(1100, n);
        total++;
        if (n !== 780) begin bad++; $display("FAIL bright_realign got=%0d want=780", n); end
    endtask

    task automatic test_dp_en();
        int f, nl, nb, nt, n;
        logic [3:0] s;
        logic [7:0] g;
        data = 16'h1234;
        dp = 4'b0100;
        skip_frame();
        grab_slot(f, nl, s, g, nb, nt);
        total++;
        if (g !== 8'h99) begin bad++; $display("FAIL dp_d0 seg=%h want 99", g); end
        grab_slot(f, nl, s, g, nb, nt);
        grab_slot(f, nl, s, g, nb, nt);
        total++;
        if (g !== 8'h24 || s !== 4'hB || nl !== 250) begin
            bad++;
            $display("FAIL dp_d2 seg=%h sel=%h lit=%0d want 24/b/250", g, s, nl);
        end
        for (int i = 0; i < 100; i++) @(negedge clk);
        total++;
        if (sel !== 4'h7 || seg !== 8'hF9) begin
            bad++;
            $display("FAIL en_before sel=%h seg=%h want 7/f9", sel, seg);
        end
        en = 1'b0;
        @(negedge clk);
        total++;
        if (sel !== 4'hF || seg !== 8'hFF) begin
            bad++;
            $display("FAIL en_off sel=%h seg=%h want f/ff", sel, seg);
        end
        wait_tick(1100, n);
        total++;
        if (n !== 159) begin bad++; $display("FAIL en_tick got=%0d want=159", n); end
        grab_slot(f, nl, s, g, nb, nt);
        total++;
        if (nl !== 0 || nb !== 0) begin
            bad++;
            $display("FAIL en_dark lit=%0d bad=%0d want 0/0", nl, nb);
        end
        wait_tick(1100, n);
        total++;
        if (n !== 780) begin bad++; $display("FAIL en_cadence got=%0d want=780", n); end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int f, nl, nb, nt, n;
        logic [3:0] s;
        logic [7:0] g;
        for (int i = 0; i < 50; i++) @(negedge clk);
        total++;
        if (sel !== 4'hE) begin bad++; $display("FAIL mid_lit sel=%h want e", sel); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (sel !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL async_reset sel=%h seg=%h ft=%b want f/ff/0", sel, seg, frame_tick);
        end
        for (int i = 0; i < 5; i++) @(negedge clk);
        #1 rst_n = 1'b1;
        grab_slot(f, nl, s, g, nb, nt);
        total++;
        if (f !== 10 || nl !== 250 || s !== 4'hE || g !== 8'hC0) begin
            bad++;
            $display("FAIL reset_restart first=%0d lit=%0d sel=%h seg=%h want 10/250/e/c0",
                     f, nl, s, g);
        end
        wait_tick(1100, n);
        total++;
        if (n !== 780) begin bad++; $display("FAIL reset_restart_tick got=%0d want=780", n); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_digits();
        test_lzb();
        test_tearing();
        test_bright();
        test_dp_en();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_mux_driver.md
SEG_MUX_DRIVER -- requirements
Module: seg_mux_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed hex digits (legal 1..8).
REQ-002 Parameter SLOT, default 260, clock cycles per digit time slot (legal 32..65535).
REQ-003 Parameter BLANK, default 10, leading all-off cycles per slot for anti-ghosting (legal 1..SLOT-16).
REQ-004 clk  input  1  100 MHz board clock, all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 data  input  4*DIGITS  hex value; nibble k drives digit k, where digit 0 is the rightmost digit.
REQ-007 dp  input  DIGITS  per-digit decimal point, 1 = lit.
REQ-008 bright  input  4  brightness code 0..15.
REQ-009 lzb  input  1  leading-zero blanking enable.
REQ-010 en  input  1  display enable.
REQ-011 sel  output  DIGITS  digit select, active LOW, registered.
REQ-012 seg  output  8  segments, active LOW, registered; [6:0] = A..G, [7] = DP.
REQ-013 frame_tick  output  1  one-cycle pulse at each frame boundary, registered.

Function
REQ-014 Slot counter cnt runs 0..SLOT-1 and wraps to 0; digit index dig advances on wrap, modulo DIGITS.
REQ-015 ON = ((SLOT-BLANK)*(bright+1))>>4, integer truncation; computed in a width wide enough that it never overflows.
REQ-016 Digit lit window: BLANK <= cnt < BLANK+ON; outside that window, sel = all ones.
REQ-017 Inside the window, sel = ~(1<<dig), unless the digit is blanked (REQ-020) or en = 0, in which case sel = all ones.
REQ-018 seg[6:0] = active-low hex decode of shadow nibble dig.
REQ-019 Hex decode table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-020 seg[7] = ~dp[dig] whenever a digit is lit; seg = 8'hFF whenever sel is all ones.
REQ-021 Shadow register loads data and dp only in the cycle where dig wraps DIGITS-1 -> 0, so there is no mid-frame tearing.
REQ-022 frame_tick is asserted for exactly one cycle at the same time as the shadow load.
REQ-023 Leading-zero blanking: with lzb = 1, digit k is blanked if every shadow nibble at k and above is 0 and k > 0; digit 0 is never blanked; a lit dp does not un-blank a digit.
REQ-024 Latency: sel, seg and frame_tick reflect the (cnt, dig) state of the previous cycle; cnt and dig are updated in the same cycle.
REQ-025 en = 0 forces blank outputs from the next cycle; counters, shadow loads and frame_tick continue to run.
REQ-026 bright and lzb are sampled every cycle; a change takes effect in the next cycle, without waiting for a frame boundary.
REQ-027 DIGITS = 1: dig stays 0, and the shadow load plus frame_tick occur on every slot wrap.

Reset
REQ-028 While rst_n = 0, the following hold immediately and independently of clk: sel = all ones, seg = 8'hFF, frame_tick = 0, cnt = 0, dig = 0, shadow = 0.
REQ-029 The first rising edge after rst_n deasserts starts at cnt = 0, dig = 0.
REQ-030 The first shadow load occurs at the end of the first full frame, so the display shows 0 until that load.
REQ-031 Reset asserted mid-slot or mid-frame aborts the current frame with no partial-frame output.

Verification
REQ-032 rst_n = 0 with clk running -> sel = 4'hF, seg = 8'hFF, frame_tick = 0 throughout.
REQ-033 DIGITS=4, data = 16'h1234, bright = 15, en = 1, after the first frame_tick -> digit 0 slot: sel = 4'b1110 for 250 cycles with seg = 8'h99, preceded by 10 blank cycles.
REQ-034 data = 16'h0050, lzb = 1 -> digits 3 and 2 never selected; digit 1 shows seg = 8'h92; digit 0 shows seg = 8'hC0. With lzb = 0 -> digits 3 and 2 show 8'hC0.
REQ-035 data changed from 16'h1111 to 16'h2222 mid-frame -> seg stays 8'hF9 until after the next frame_tick, then becomes 8'hA4.
REQ-036 bright = 0 -> each lit window is exactly 15 cycles; frame_tick period is exactly 1040 cycles.
REQ-037 dp = 4'b0100, en toggled to 0 mid-slot -> digit 2 shows seg[7] = 0; after en falls, outputs go all ones on the next cycle while frame_tick cadence is unchanged.
